// File: rtl/fwd_pkg.sv
// Shared forwarding definitions: default datapath widths used by decode/EX and
// the select-code encoding of the forwarding stage.
package fwd_pkg;

  localparam int FWD_DW       = 32;
  localparam int FWD_AW       = 5;
  localparam int FWD_SEL_RF   = 0;
  localparam int FWD_SEL_MAXW = 4;  // enough for NSRC up to 8

  typedef logic [FWD_SEL_MAXW-1:0] fwd_sel_t;

  // Width of a select code covering the register file plus nsrc sources.
  function automatic int fwd_sel_width(input int nsrc);
    return $clog2(nsrc + 1);
  endfunction

endpackage

// File: rtl/fwd_mux_stage_if.sv
// Request/operand bus of the forwarding stage: decode request, writeback
// sources, registered operand handshake and the load-use stall request.
interface fwd_mux_stage_if
  import fwd_pkg::*;
#(
  parameter int DW   = FWD_DW,
  parameter int AW   = FWD_AW,
  parameter int NSRC = 3,
  parameter int SELW = fwd_sel_width(NSRC)
);

  logic               in_valid;
  logic               in_ready;
  logic [AW-1:0]      in_raddr;
  logic [DW-1:0]      in_rfdata;
  logic [NSRC-1:0]    src_wen;
  logic [NSRC-1:0]    src_pend;
  logic [NSRC*AW-1:0] src_waddr;
  logic [NSRC*DW-1:0] src_wdata;
  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_data;
  logic [SELW-1:0]    out_sel;
  logic               hazard;

  modport master (
    output in_valid, in_raddr, in_rfdata, src_wen, src_pend, src_waddr, src_wdata, out_ready,
    input  in_ready, out_valid, out_data, out_sel, hazard
  );

  modport slave (
    input  in_valid, in_raddr, in_rfdata, src_wen, src_pend, src_waddr, src_wdata, out_ready,
    output in_ready, out_valid, out_data, out_sel, hazard
  );

endinterface

// File: rtl/fwd_prio_sel.sv
// Combinational priority match of one source register against NSRC writeback
// sources; the lowest (youngest) matching index wins, else register-file data.
module fwd_prio_sel
  import fwd_pkg::*;
#(
  parameter int DW   = FWD_DW,
  parameter int AW   = FWD_AW,
  parameter int NSRC = 3,
  parameter int SELW = fwd_sel_width(NSRC)
) (
  input  logic [AW-1:0]      raddr,
  input  logic [DW-1:0]      rfdata,
  input  logic [NSRC-1:0]    src_wen,
  input  logic [NSRC-1:0]    src_pend,
  input  logic [NSRC*AW-1:0] src_waddr,
  input  logic [NSRC*DW-1:0] src_wdata,
  output logic [SELW-1:0]    sel,
  output logic [DW-1:0]      data,
  output logic               pend
);

  logic raddr_nz;

  assign raddr_nz = |raddr;

  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    sel  = SELW'(FWD_SEL_RF);
    data = raddr_nz ? rfdata : '0;
    pend = 1'b0;
    // NOTE: blocking '=' in combinational logic; walking from oldest to
    // youngest lets a later (lower-index) match overwrite an earlier one.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (src_wen[i] && raddr_nz && (src_waddr[i*AW +: AW] == raddr)) begin
        sel  = SELW'(i + 1);
        data = src_wdata[i*DW +: DW];
        pend = src_pend[i];
      end
    end
  end

endmodule

// File: rtl/fwd_mux_stage.sv
// Operand-forwarding stage: priority forwarding, load-use hazard detection and a
// registered valid/ready ID/EX boundary with flush. Optional counters: FWD_MUX_STATS_EN.
module fwd_mux_stage
  import fwd_pkg::*;
#(
  parameter int DW   = FWD_DW,
  parameter int AW   = FWD_AW,
  parameter int NSRC = 3,
  parameter int SELW = fwd_sel_width(NSRC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
`ifdef FWD_MUX_STATS_EN
  output logic [NSRC*32-1:0] stat_fwd,
  output logic [31:0]        stat_haz,
`endif
  fwd_mux_stage_if.slave     bus
);

  logic [SELW-1:0] sel;
  logic [DW-1:0]   sel_data;
  logic            sel_pend;
  logic            capture;

  fwd_prio_sel #(
    .DW  (DW),
    .AW  (AW),
    .NSRC(NSRC),
    .SELW(SELW)
  ) u_prio_sel (
    .raddr    (bus.in_raddr),
    .rfdata   (bus.in_rfdata),
    .src_wen  (bus.src_wen),
    .src_pend (bus.src_pend),
    .src_waddr(bus.src_waddr),
    .src_wdata(bus.src_wdata),
    .sel      (sel),
    .data     (sel_data),
    .pend     (sel_pend)
  );

  assign bus.hazard   = bus.in_valid && sel_pend;
  assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !bus.hazard;
  assign capture      = bus.in_valid && bus.in_ready;

  // Flush drops valid but leaves data/sel untouched to avoid needless toggling.
  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sel   <= SELW'(FWD_SEL_RF);
    end else if (flush) begin
      bus.out_valid <= 1'b0;
    end else if (capture) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= sel_data;
      bus.out_sel   <= sel;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

`ifdef FWD_MUX_STATS_EN
  logic [31:0] fwd_cnt [NSRC];
  logic [31:0] haz_cnt;

  for (genvar i = 0; i < NSRC; i++) begin : g_fwd_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fwd_cnt[i] <= '0;
      end else if (capture && (sel == SELW'(i + 1)) && (fwd_cnt[i] != '1)) begin
        fwd_cnt[i] <= fwd_cnt[i] + 32'd1;
      end
    end
    assign stat_fwd[i*32 +: 32] = fwd_cnt[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      haz_cnt <= '0;
    end else if (bus.hazard && (haz_cnt != '1)) begin
      haz_cnt <= haz_cnt + 32'd1;
    end
  end
  assign stat_haz = haz_cnt;
`endif

endmodule

// File: tb/tb_fwd_mux_stage.sv
// Directed self-checking bench for fwd_mux_stage (NSRC=3): forwarding priority,
// zero register, load-use hazard, back-pressure, flush and asynchronous reset.
module tb_fwd_mux_stage;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NSRC = 3;
  localparam int SELW = $clog2(NSRC + 1);

  logic clk;
  logic rst_n;
  logic flush;
  int   checks   = 0;
  int   failures = 0;

`ifdef FWD_MUX_STATS_EN
  logic [NSRC*32-1:0] stat_fwd;
  logic [31:0]        stat_haz;
`endif

  fwd_mux_stage_if #(.DW(DW), .AW(AW), .NSRC(NSRC), .SELW(SELW)) bus ();

  fwd_mux_stage #(
    .DW  (DW),
    .AW  (AW),
    .NSRC(NSRC),
    .SELW(SELW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
`ifdef FWD_MUX_STATS_EN
    .stat_fwd(stat_fwd),
    .stat_haz(stat_haz),
`endif
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic en, input logic pend,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.src_wen[i]            = en;
    bus.src_pend[i]           = pend;
    bus.src_waddr[i*AW +: AW] = addr;
    bus.src_wdata[i*DW +: DW] = data;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] d,
                           input logic [31:0] s);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
    check({tag, "_data"}, bus.out_data, d);
    check({tag, "_sel"}, 32'(bus.out_sel), s);
  endtask

  initial begin
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_raddr  = '0;
    bus.in_rfdata = '0;
    bus.src_wen   = '0;
    bus.src_pend  = '0;
    bus.src_waddr = '0;
    bus.src_wdata = '0;
    bus.out_ready = 1'b1;

    #12;
    check_out("reset", 1'b0, 32'h0, 32'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_hazard", 32'(bus.hazard), 32'd0);
    rst_n = 1'b1;
    tick();

    // Two older sources match; source 1 is the youngest match.
    bus.in_valid  = 1'b1;
    bus.in_raddr  = 5'd5;
    bus.in_rfdata = 32'h1234;
    set_src(0, 1'b0, 1'b0, 5'd7, 32'h0);
    set_src(1, 1'b1, 1'b0, 5'd5, 32'hAAAA);
    set_src(2, 1'b1, 1'b0, 5'd5, 32'hBBBB);
    #1;
    check("fwd_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check_out("fwd_src1", 1'b1, 32'hAAAA, 32'd2);

    // No enabled source: register file, accepted back to back.
    bus.src_wen = '0;
    tick();
    check_out("rf_sel", 1'b1, 32'h1234, 32'd0);

    // Zero register never forwards and reads as zero.
    bus.in_raddr = 5'd0;
    set_src(0, 1'b1, 1'b0, 5'd0, 32'hFFFF);
    tick();
    check_out("zero_reg", 1'b1, 32'h0, 32'd0);

    // Pending on an older matching source is ignored.
    bus.in_raddr = 5'd9;
    set_src(0, 1'b1, 1'b0, 5'd9, 32'h55);
    set_src(1, 1'b1, 1'b1, 5'd9, 32'h66);
    bus.src_wen[2] = 1'b0;
    #1;
    check("old_pend_hazard", 32'(bus.hazard), 32'd0);
    tick();
    check_out("old_pend", 1'b1, 32'h55, 32'd1);

    // Load-use: winning source pending for two cycles.
    bus.in_raddr = 5'd6;
    bus.src_wen  = '0;
    set_src(0, 1'b1, 1'b1, 5'd6, 32'h0);
    #1;
    check("lu1_hazard", 32'(bus.hazard), 32'd1);
    check("lu1_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    check("lu1_drained", 32'(bus.out_valid), 32'd0);
    check("lu2_hazard", 32'(bus.hazard), 32'd1);
    check("lu2_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    check("lu2_no_capture", 32'(bus.out_valid), 32'd0);
    set_src(0, 1'b1, 1'b0, 5'd6, 32'h77);
    #1;
    check("lu3_hazard", 32'(bus.hazard), 32'd0);
    check("lu3_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check_out("lu3", 1'b1, 32'h77, 32'd1);

    // Hazard is gated by in_valid.
    bus.in_valid = 1'b0;
    bus.src_pend[0] = 1'b1;
    #1;
    check("idle_hazard", 32'(bus.hazard), 32'd0);
    bus.src_pend = '0;
    bus.src_wen  = '0;

    // Back-pressure for three cycles with a request waiting.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_raddr  = 5'd3;
    bus.in_rfdata = 32'h3333;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      check_out("bp_hold", 1'b1, 32'h77, 32'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    check_out("bp_release", 1'b1, 32'h3333, 32'd0);
    bus.in_rfdata = 32'h4444;
    tick();
    check_out("b2b", 1'b1, 32'h4444, 32'd0);
    bus.in_valid = 1'b0;
    tick();
    check("drain_valid", 32'(bus.out_valid), 32'd0);

    // Flush discards a same-cycle capture; data/sel are kept.
    bus.in_valid  = 1'b1;
    bus.in_rfdata = 32'h5555;
    flush         = 1'b1;
    tick();
    check_out("flush", 1'b0, 32'h4444, 32'd0);
    flush = 1'b0;

    // Asynchronous reset while an operand is held.
    bus.in_rfdata = 32'h6666;
    tick();
    check_out("pre_reset", 1'b1, 32'h6666, 32'd0);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_reset", 1'b0, 32'h0, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_mux_stage.md
Name: fwd_mux_stage

Overview:
- Parametrised operand-forwarding stage for the in-order pipeline. Successor to the fixed 4:1 forwarding select.
- Per operand, compares the source register against NSRC in-flight writeback sources and picks the youngest match, else register-file data.
- Detects load-use hazards and holds the operand.
- Registers the selected operand into the ID/EX boundary behind a valid/ready handshake, with flush.

Parameters:
- DW, 32, operand/data width.
- AW, 5, register address width.
- NSRC, 3, number of forwarding sources (index 0 = youngest stage, e.g. EX/MEM); legal range 1..8.
- SELW, $clog2(NSRC+1), width of the select code.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous; kills the registered operand.
- in_valid  input  1  decode stage presents an operand request.
- in_ready  output  1  stage can accept a request this cycle.
- in_raddr  input  AW  source register address.
- in_rfdata  input  DW  register-file read data for in_raddr.
- src_wen  input  NSRC  per-source write-enable (valid destination).
- src_pend  input  NSRC  per-source result not yet available (load in flight).
- src_waddr  input  NSRC*AW  packed destination addresses; source i at [i*AW +: AW].
- src_wdata  input  NSRC*DW  packed result data; source i at [i*DW +: DW].
- out_valid  output  1  registered operand valid.
- out_ready  input  1  downstream accepts the operand.
- out_data  output  DW  registered operand.
- out_sel  output  SELW  registered select: 0 = register file, i+1 = source i.
- hazard  output  1  combinational load-use stall request to the front end.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_sel=0. hazard and in_ready follow their equations.
- Match i = src_wen[i] && src_waddr_i == in_raddr && in_raddr != 0. Address 0 never forwards; out_data is 0 for address 0 regardless of in_rfdata.
- Priority: lowest matching index wins. If there is no match, select the register file.
- hazard = in_valid && winning source has src_pend set. Pending state of older matching sources is ignored.
- in_ready = (!out_valid || out_ready) && !hazard.
- Capture when in_valid && in_ready:
  - out_data is updated with the selected data, out_sel with the code, and out_valid is set.
  - Latency is 1 cycle from accepted request to out_valid.
- If out_valid && out_ready && no capture, out_valid clears next cycle.
- If out_valid && !out_ready, out_data and out_sel hold stable; back-pressure propagates via in_ready=0.
- Hazard cycles:
  - No capture.
  - The request must be held by the driver (in_valid, in_raddr stable).
  - The request re-evaluates each cycle and is accepted the cycle src_pend drops or the source retires.
- flush wins over everything:
  - Next cycle out_valid=0; any capture that cycle is discarded.
  - out_data/out_sel are don't-care but kept at the last value (no toggle).
- Simultaneous drain and capture (out_valid && out_ready && in accept): out_valid stays 1 with new data, giving full throughput of one operand per cycle.
- Selection is a priority chain over NSRC; no arithmetic.

Optional Feature:
- Macro FWD_MUX_STATS_EN.
- When defined, adds outputs stat_fwd (NSRC*32, packed per-source forward counts) and stat_haz (32, hazard cycles).
  - Counters increment on accepted captures with out_sel==i+1, and on each cycle hazard=1.
  - Counters saturate at 32'hFFFF_FFFF and are cleared by rst_n only; flush does not clear them.
- When undefined: no stat ports, no counter flops; behaviour otherwise identical.

Decomposition:
- Shared package fwd_pkg:
  - FWD_SEL_RF = 0 constant.
  - Select-code typedef helper.
  - Default DW/AW constants shared with decode/EX.
- One natural sub-module, fwd_prio_sel:
  - Combinational priority match over NSRC.
  - Returns the select code, selected data and pend flag.
  - Reused for the second operand by instantiating fwd_mux_stage twice.

Test Plan:
- Reset mid-capture: pulse rst_n low while out_valid=1 -> out_valid, out_data, out_sel go to 0 immediately, asynchronously.
- NSRC=3, in_raddr=5:
  - src_wen=3'b110, waddr1=waddr2=5, wdata1=0xAAAA, wdata2=0xBBBB -> next cycle out_data=0xAAAA, out_sel=2.
  - Same stimulus with src_wen=0 and in_rfdata=0x1234 -> out_data=0x1234, out_sel=0.
- Zero register: in_raddr=0, src_wen=3'b001, waddr0=0, wdata0=0xFFFF -> out_data=0, out_sel=0.
- Load-use: src0 matches with src_pend[0]=1 for 2 cycles -> hazard=1, in_ready=0 for 2 cycles. In cycle 3 (pend=0, wdata0=0x77) -> capture, out_data=0x77, out_sel=1.
- Back-pressure and flush:
  - out_ready=0 for 3 cycles -> out_data stable, in_ready=0; then out_ready=1 with a new request -> back-to-back throughput.
  - flush together with an accepted request -> out_valid=0 next cycle.
